sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the 16x8 buffer.
//  - Adds almost-full/almost-empty thresholds, an occupancy level output and sticky overflow/underflow errors.
//  - Selectable first-word-fall-through (FWFT) or registered-read mode.
//  - Simultaneous read/write counting is exact; count changes only on accepted operations.
//  - Sits between producer/consumer stages in the datapath; drop-in for the 16x8 buffer with FWFT=1.
// PARAMETERS
//  DATA_WIDTH  8   data word width, >=1
//  DEPTH       16  number of entries; power of 2, >=2
//  AF_THRESH   12  o_almost_full asserted when level >= AF_THRESH (1..DEPTH)
//  AE_THRESH   4   o_almost_empty asserted when level <= AE_THRESH (0..DEPTH-1)
//  FWFT        1   1: head word visible on o_rd_data; 0: registered read, 1-cycle latency
//  localparam ADDR_WIDTH = $clog2(DEPTH); LEVEL_WIDTH = ADDR_WIDTH+1
// PORTS
//  i_clk           in   1            clock, rising edge
//  i_rst           in   1            reset, asynchronous, active-high
//  i_wr_en         in   1            write request
//  i_wr_data       in   DATA_WIDTH   write data
//  i_rd_en         in   1            read request
//  i_clr_err       in   1            clears sticky o_overflow/o_underflow
//  o_rd_data       out  DATA_WIDTH   read data (see BEHAVIOUR)
//  o_rd_valid      out  1            FWFT=1: equals !o_empty; FWFT=0: 1-cycle pulse with read data
//  o_full          out  1            level == DEPTH
//  o_empty         out  1            level == 0
//  o_almost_full   out  1            level >= AF_THRESH
//  o_almost_empty  out  1            level <= AE_THRESH
//  o_level         out  LEVEL_WIDTH  current occupancy, 0..DEPTH
//  o_overflow      out  1            sticky: write attempted while full
//  o_underflow     out  1            sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (async, any time, including mid-burst):
//    - Pointers = 0, level = 0; o_empty = 1, o_almost_empty = 1; o_full = 0, o_almost_full = 0.
//    - o_overflow = 0, o_underflow = 0, o_rd_valid = 0, o_rd_data = 0.
//    - Memory contents not cleared.
//  - Accept rules, based on registered state at the clock edge:
//    - wr_acc = i_wr_en & !o_full
//    - rd_acc = i_rd_en & !o_empty
//  - Full + rd + wr: read accepted, write rejected (overflow set). Empty + rd + wr: write accepted, read rejected (underflow set).
//  - Level: level <= level + wr_acc - rd_acc. Both accepted -> level unchanged.
//  - All flags are decoded from the registered level; no combinational path from i_* to any flag.
//  - Pointers are ADDR_WIDTH bits and wrap naturally DEPTH-1 -> 0. Write stores at wr_ptr; read advances rd_ptr.
//  - FWFT=1: o_rd_data = mem[rd_ptr] when !o_empty, else 0. A write to an empty FIFO is visible the next cycle.
//  - FWFT=0: on rd_acc, o_rd_data <= mem[rd_ptr] and o_rd_valid <= 1 the next cycle; otherwise o_rd_valid <= 0. o_rd_data holds its last value.
//  - Errors: o_overflow set on i_wr_en & o_full; o_underflow set on i_rd_en & o_empty. Cleared by i_clr_err; set wins over clear in the same cycle.
//  - Parameter legality (power-of-2 DEPTH, threshold ranges) checked at elaboration with $error.
// STRUCTURE
//  - Package fifo_pkg: fifo_status_t struct {full, empty, almost_full, almost_empty, overflow, underflow} and default constants.
//  - Sub-module fifo_ram: simple dual-port DEPTH x DATA_WIDTH array; synchronous write, asynchronous read.
//  - Top holds pointers, level counter, flag decode, error bits and the FWFT output stage.
// TESTING (defaults unless noted)
//  - Reset mid-burst: 5 writes, assert i_rst -> o_level = 0, o_empty = 1, o_rd_valid = 0, flags cleared, the same cycle (async).
//  - Fill/drain: write 0x00..0x0F -> o_full = 1, o_level = 16, o_almost_full from level 12; read 16 -> data 0x00..0x0F in order, o_empty = 1.
//  - Wrap: write 10, read 10, write 12, read 12 -> order preserved across wrap, level tracks exactly.
//  - Simultaneous: at level 16 rd+wr -> level 15, overflow = 1; at level 0 rd+wr -> level 1, underflow = 1; at level 5 -> level 5.
//  - Errors: write at full sets o_overflow; i_clr_err with a new violation in the same cycle keeps it at 1; i_clr_err alone clears it.
//  - FWFT=0: write 0xA5, read -> o_rd_valid pulses 1 cycle after rd_en, o_rd_data = 0xA5 and held afterwards.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the flagged synchronous FIFO.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  localparam int unsigned DEF_DATA_WIDTH = 32'd8;
  localparam int unsigned DEF_DEPTH      = 32'd16;
  localparam int unsigned DEF_AF_THRESH  = 32'd12;
  localparam int unsigned DEF_AE_THRESH  = 32'd4;
  localparam int unsigned DEF_FWFT       = 32'd1;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 32'd8,
  parameter int unsigned DEPTH      = 32'd16,
  parameter int unsigned ADDR_WIDTH = 32'd4
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Storage write port; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_r[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_r[i_rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with level output, almost-full/empty thresholds,
// sticky overflow/underflow errors and selectable FWFT or registered read.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned AF_THRESH  = DEF_AF_THRESH,
  parameter int unsigned AE_THRESH  = DEF_AE_THRESH,
  parameter int unsigned FWFT       = DEF_FWFT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [DATA_WIDTH-1:0]    i_wr_data,
  input  logic                     i_rd_en,
  input  logic                     i_clr_err,
  output logic [DATA_WIDTH-1:0]    o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int unsigned ADDR_WIDTH  = $clog2(DEPTH);
  localparam int unsigned LEVEL_WIDTH = ADDR_WIDTH + 32'd1;

  if (!is_pow2(DEPTH) || (DEPTH < 32'd2)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of 2 and >= 2");
  end
  if ((AF_THRESH < 32'd1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_flags: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH > (DEPTH - 32'd1)) begin : g_bad_ae
    $error("sync_fifo_flags: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0]  wr_ptr_r;
  logic [ADDR_WIDTH-1:0]  rd_ptr_r;
  logic [LEVEL_WIDTH-1:0] level_r;
  logic                   overflow_r;
  logic                   underflow_r;
  logic                   wr_acc_s;
  logic                   rd_acc_s;
  logic [DATA_WIDTH-1:0]  ram_rd_data_s;
  fifo_status_t           status_s;

  // Flag decode from the registered level only, so no input reaches a flag.
  always_comb begin
    status_s              = '0;
    status_s.full         = (level_r == LEVEL_WIDTH'(DEPTH));
    status_s.empty        = (level_r == LEVEL_WIDTH'(0));
    status_s.almost_full  = (level_r >= LEVEL_WIDTH'(AF_THRESH));
    status_s.almost_empty = (level_r <= LEVEL_WIDTH'(AE_THRESH));
    status_s.overflow     = overflow_r;
    status_s.underflow    = underflow_r;
  end

  assign wr_acc_s = i_wr_en & ~status_s.full;
  assign rd_acc_s = i_rd_en & ~status_s.empty;

  // Pointers and occupancy; both accepted leaves the level unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_r <= level_r + LEVEL_WIDTH'(1);
        2'b01:   level_r <= level_r - LEVEL_WIDTH'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky error bits; a new violation wins over a clear in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (i_wr_en && status_s.full) begin
        overflow_r <= 1'b1;
      end else if (i_clr_err) begin
        overflow_r <= 1'b0;
      end
      if (i_rd_en && status_s.empty) begin
        underflow_r <= 1'b1;
      end else if (i_clr_err) begin
        underflow_r <= 1'b0;
      end
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (wr_acc_s),
    .i_wr_addr (wr_ptr_r),
    .i_wr_data (i_wr_data),
    .i_rd_addr (rd_ptr_r),
    .o_rd_data (ram_rd_data_s)
  );

  if (FWFT != 32'd0) begin : g_fwft
    // Head word shown directly; forced to zero while empty.
    always_comb begin
      if (status_s.empty) begin
        o_rd_data = '0;
      end else begin
        o_rd_data = ram_rd_data_s;
      end
    end
    assign o_rd_valid = ~status_s.empty;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_valid_r;

    // Registered read: data one cycle after an accepted read, held otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        rd_data_r  <= '0;
        rd_valid_r <= 1'b0;
      end else begin
        rd_valid_r <= rd_acc_s;
        if (rd_acc_s) begin
          rd_data_r <= ram_rd_data_s;
        end
      end
    end
    assign o_rd_data  = rd_data_r;
    assign o_rd_valid = rd_valid_r;
  end

  assign o_full         = status_s.full;
  assign o_empty        = status_s.empty;
  assign o_almost_full  = status_s.almost_full;
  assign o_almost_empty = status_s.almost_empty;
  assign o_overflow     = status_s.overflow;
  assign o_underflow    = status_s.underflow;
  assign o_level        = level_r;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: FWFT instance plus a registered-read instance.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, af, ae, ovf, unf;
  logic [4:0] level;

  logic       r_wr_en, r_rd_en, r_clr_err;
  logic [7:0] r_wr_data;
  logic [7:0] r_rd_data;
  logic       r_rd_valid, r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
  logic [4:0] r_level;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sb_q[$];
  logic [7:0] r_sb_q[$];
  int         lvl_m;
  logic       ov_m, un_m;
  logic       exp_rd_ok;
  logic [7:0] exp_rd;

  always #5 clk = ~clk;

  sync_fifo_flags u_dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_rd_en(rd_en),
    .i_clr_err(clr_err), .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_full(full),
    .o_empty(empty), .o_almost_full(af), .o_almost_empty(ae), .o_level(level),
    .o_overflow(ovf), .o_underflow(unf)
  );

  sync_fifo_flags #(.FWFT(0)) u_reg (
    .i_clk(clk), .i_rst(rst), .i_wr_en(r_wr_en), .i_wr_data(r_wr_data), .i_rd_en(r_rd_en),
    .i_clr_err(r_clr_err), .o_rd_data(r_rd_data), .o_rd_valid(r_rd_valid), .o_full(r_full),
    .o_empty(r_empty), .o_almost_full(r_af), .o_almost_empty(r_ae), .o_level(r_level),
    .o_overflow(r_ovf), .o_underflow(r_unf)
  );

  function automatic logic [3:0] exp_flags(input int l);
    return {l == 16, l == 0, l >= 12, l <= 4};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of inputs and updates the reference model (no checking).
  task automatic drive(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    logic wacc, racc;
    wr_en = wr; wr_data = d; rd_en = rd; clr_err = clr;
    wacc = wr && (lvl_m < 16);
    racc = rd && (lvl_m > 0);
    exp_rd_ok = racc;
    exp_rd = 8'h00;
    if (racc) exp_rd = sb_q.pop_front();
    if (wacc) sb_q.push_back(d);
    if (wr && (lvl_m == 16)) ov_m = 1'b1;
    else if (clr) ov_m = 1'b0;
    if (rd && (lvl_m == 0)) un_m = 1'b1;
    else if (clr) un_m = 1'b0;
    lvl_m = lvl_m + (wacc ? 1 : 0) - (racc ? 1 : 0);
  endtask

  task automatic reset_model();
    sb_q.delete();
    r_sb_q.delete();
    lvl_m = 0; ov_m = 1'b0; un_m = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (level !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", level); end
    vectors++;
    if ({full, empty, af, ae, ovf, unf, rd_valid} !== 7'b0101000) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 0101000", {full, empty, af, ae, ovf, unf, rd_valid});
    end
    vectors++;
    if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
    vectors++;
    if ({r_rd_valid, r_rd_data, r_level} !== 14'd0) begin
      miscompares++; $display("FAIL reset_reg_inst: got valid=%b data=%0h level=%0d expected zeros", r_rd_valid, r_rd_data, r_level);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      step();
      vectors++;
      if (level !== 5'(lvl_m) || {full, empty, af, ae} !== exp_flags(lvl_m)) begin
        miscompares++; $display("FAIL fill_state: got level=%0d flags=%b expected level=%0d flags=%b", level, {full, empty, af, ae}, lvl_m, exp_flags(lvl_m));
      end
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (!exp_rd_ok || rd_data !== exp_rd) begin
        miscompares++; $display("FAIL drain_data: got %0h expected %0h", rd_data, exp_rd);
      end
      step();
      vectors++;
      if (level !== 5'(lvl_m) || {full, empty, af, ae} !== exp_flags(lvl_m)) begin
        miscompares++; $display("FAIL drain_state: got level=%0d flags=%b expected level=%0d flags=%b", level, {full, empty, af, ae}, lvl_m, exp_flags(lvl_m));
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    int counts[4] = '{10, 10, 12, 12};
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < counts[p]; i++) begin
        drive(p % 2 == 0, 8'($urandom_range(255)), p % 2 == 1, 1'b0);
        if (p % 2 == 1) begin
          vectors++;
          if (rd_data !== exp_rd) begin miscompares++; $display("FAIL wrap_data: got %0h expected %0h", rd_data, exp_rd); end
        end
        step();
        vectors++;
        if (level !== 5'(lvl_m) || {full, empty, af, ae} !== exp_flags(lvl_m)) begin
          miscompares++; $display("FAIL wrap_state: got level=%0d flags=%b expected level=%0d", level, {full, empty, af, ae}, lvl_m);
        end
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) begin drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0); step(); end
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    vectors++;
    if (rd_data !== exp_rd) begin miscompares++; $display("FAIL simul_full_data: got %0h expected %0h", rd_data, exp_rd); end
    step();
    vectors++;
    if (level !== 5'd15 || ovf !== 1'b1 || level !== 5'(lvl_m)) begin
      miscompares++; $display("FAIL simul_full: got level=%0d ovf=%b expected level=15 ovf=1", level, ovf);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1); step();
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (rd_data !== exp_rd) begin miscompares++; $display("FAIL simul_drain_data: got %0h expected %0h", rd_data, exp_rd); end
      step();
    end
    drive(1'b1, 8'h3C, 1'b1, 1'b0);
    vectors++;
    if (rd_data !== 8'h00) begin miscompares++; $display("FAIL simul_empty_data: got %0h expected 0", rd_data); end
    step();
    vectors++;
    if (level !== 5'd1 || unf !== 1'b1 || level !== 5'(lvl_m)) begin
      miscompares++; $display("FAIL simul_empty: got level=%0d unf=%b expected level=1 unf=1", level, unf);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1); step();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 8'(8'h50 + i), 1'b0, 1'b0); step(); end
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    vectors++;
    if (rd_data !== 8'h3C || rd_data !== exp_rd) begin miscompares++; $display("FAIL simul_mid_data: got %0h expected 3c", rd_data); end
    step();
    vectors++;
    if (level !== 5'd5 || {ovf, unf} !== 2'b00) begin
      miscompares++; $display("FAIL simul_mid: got level=%0d err=%b expected level=5 err=00", level, {ovf, unf});
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (rd_data !== exp_rd) begin miscompares++; $display("FAIL simul_tail_data: got %0h expected %0h", rd_data, exp_rd); end
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_errors();
    logic [2:0] err_ops[4] = '{3'b100, 3'b101, 3'b001, 3'b000};
    for (int i = 0; i < 16; i++) begin drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0); step(); end
    for (int i = 0; i < 4; i++) begin
      drive(err_ops[i][2], 8'hFF, err_ops[i][1], err_ops[i][0]);
      step();
      vectors++;
      if ({ovf, unf} !== {ov_m, un_m}) begin
        miscompares++; $display("FAIL overflow_seq%0d: got ovf=%b unf=%b expected ovf=%b unf=%b", i, ovf, unf, ov_m, un_m);
      end
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (rd_data !== exp_rd) begin miscompares++; $display("FAIL errors_drain_data: got %0h expected %0h", rd_data, exp_rd); end
      step();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    vectors++;
    if (unf !== 1'b1 || ovf !== 1'b0) begin miscompares++; $display("FAIL underflow_set: got unf=%b ovf=%b expected 1 0", unf, ovf); end
    drive(1'b0, 8'h00, 1'b0, 1'b1); step();
    vectors++;
    if (unf !== 1'b0 || level !== 5'd0) begin miscompares++; $display("FAIL underflow_clr: got unf=%b level=%0d expected 0 0", unf, level); end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0); step(); end
    drive(1'b1, 8'hC5, 1'b0, 1'b0);
    vectors++;
    if (level !== 5'd5) begin miscompares++; $display("FAIL burst_level: got %0d expected 5", level); end
    rst = 1'b1;
    #1;
    vectors++;
    if (level !== 5'd0 || {full, empty, af, ae, ovf, unf, rd_valid} !== 7'b0101000) begin
      miscompares++; $display("FAIL async_reset: got level=%0d flags=%b expected level=0 flags=0101000", level, {full, empty, af, ae, ovf, unf, rd_valid});
    end
    reset_model();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    vectors++;
    if (level !== 5'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL post_reset: got level=%0d empty=%b expected 0 1", level, empty); end
  endtask

  task automatic test_fwft0();
    r_wr_en = 1'b1; r_wr_data = 8'hA5; r_sb_q.push_back(8'hA5);
    step();
    r_wr_en = 1'b0; r_rd_en = 1'b1;
    vectors++;
    if (r_rd_valid !== 1'b0 || r_level !== 5'd1) begin
      miscompares++; $display("FAIL reg_pre_read: got valid=%b level=%0d expected 0 1", r_rd_valid, r_level);
    end
    step();
    r_rd_en = 1'b0;
    exp_rd = r_sb_q.pop_front();
    vectors++;
    if (r_rd_valid !== 1'b1 || r_rd_data !== exp_rd) begin
      miscompares++; $display("FAIL reg_read: got valid=%b data=%0h expected 1 %0h", r_rd_valid, r_rd_data, exp_rd);
    end
    step();
    vectors++;
    if (r_rd_valid !== 1'b0 || r_rd_data !== 8'hA5 || r_empty !== 1'b1) begin
      miscompares++; $display("FAIL reg_hold: got valid=%b data=%0h empty=%b expected 0 a5 1", r_rd_valid, r_rd_data, r_empty);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    r_wr_en = 1'b0; r_rd_en = 1'b0; r_clr_err = 1'b0; r_wr_data = 8'h00;
    reset_model();
    exp_rd_ok = 1'b0; exp_rd = 8'h00;
    repeat (2) step();
    test_reset();
    rst = 1'b0;
    step();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_errors();
    test_reset_mid_burst();
    test_fwft0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
